// File: rtl/gc_arb_pkg.sv
// ----------------------------------------------------------------------------
// gc_arb_pkg
// Shared definitions for the gamecube controller port arbiter.
//   - S_IDLE / S_GRANT / S_ACTIVE / S_RELEASE : arbiter FSM encodings
//   - TMR_W : width of the grant / holdoff timer
//   - tmr_inc() : saturating timer increment (timers never wrap)
// Optional feature macro used by the arbiter: GC_ARB_STATS_EN.
// ----------------------------------------------------------------------------
package gc_arb_pkg;

    localparam int ST_W = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int TMR_W = 16;

    // Saturating increment: a stuck timer holds at all-ones rather than
    // wrapping back into a range that could re-trigger a compare.
    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (&t) ? t : t + 16'd1;
    endfunction

endpackage

// File: rtl/gc_rr_pick.sv
// ----------------------------------------------------------------------------
// gc_rr_pick
// Combinational round-robin picker. Searches i_req starting at i_last+1
// (mod N) and returns the first requesting index.
// Ports:
//   i_req    [N]      request vector (one bit per port)
//   i_last   [SEL_W]  index granted most recently
//   o_any             at least one request present
//   o_idx    [SEL_W]  winning index (0 when o_any is low)
//   o_onehot [N]      one-hot form of o_idx (all-zero when o_any is low)
// ----------------------------------------------------------------------------
module gc_rr_pick
    import gc_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot
);

    logic [SEL_W-1:0] w_cand;

    always_comb begin
        o_any    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_cand   = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = SEL_W'((int'(i_last) + 1 + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gc_port_arbiter.sv
// ----------------------------------------------------------------------------
// gc_port_arbiter
// Shares one gamecube controller engine (serial rx/tx + response FSM) among
// N console ports. The first port whose rx line falls is granted the engine;
// the grant is held until the engine has finished responding and the line
// has stayed idle-high for HOLDOFF clocks. Falls on other ports while the
// engine is owned are dropped.
//
// Handshake: there is no valid/ready pair here. Ownership is signalled by
// o_grant (one-hot, zero when idle) and o_core_sel; the engine reports
// ownership in use through i_core_busy. o_core_sel is stable for the whole
// grant and keeps its last value after release.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   i_port_rx [N]   synchronized per-port rx, idle high
//   o_port_tx [N]   per-port tx, 1 = released
//   o_core_rx       rx into the shared engine (1 when nothing granted)
//   i_core_tx       tx from the shared engine
//   i_core_busy     engine is not idle
//   o_core_sel      granted port index
//   o_grant   [N]   one-hot grant
//   o_drop_count    8 bits per port dropped-request counters (GC_ARB_STATS_EN)
//   o_state         current FSM state (debug)
// Optional feature: define GC_ARB_STATS_EN to build the drop counters.
// ----------------------------------------------------------------------------
module gc_port_arbiter
    import gc_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 2000,
    parameter int HOLDOFF = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PORTS-1:0]   i_port_rx,
    output logic [N_PORTS-1:0]   o_port_tx,
    output logic                 o_core_rx,
    input  logic                 i_core_tx,
    input  logic                 i_core_busy,
    output logic [SEL_W-1:0]     o_core_sel,
    output logic [N_PORTS-1:0]   o_grant,
`ifdef GC_ARB_STATS_EN
    output logic [8*N_PORTS-1:0] o_drop_count,
`endif
    output logic [ST_W-1:0]      o_state
);

    logic [N_PORTS-1:0] r_rx_prev;
    logic [N_PORTS-1:0] r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_last;
    logic [ST_W-1:0]    r_state;
    logic [TMR_W-1:0]   r_timer;

    logic [N_PORTS-1:0] w_fall;
    logic               w_any;
    logic [SEL_W-1:0]   w_idx;
    logic [N_PORTS-1:0] w_onehot;
    logic               w_sel_rx;
    logic [TMR_W-1:0]   w_tmr_inc;
    logic               w_rel_done;
    logic [N_PORTS-1:0] w_drop;

    logic [ST_W-1:0]    w_state_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [N_PORTS-1:0] w_grant_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_last_nxt;

    assign w_fall     = r_rx_prev & ~i_port_rx;
    assign w_sel_rx   = i_port_rx[r_sel];
    assign w_tmr_inc  = tmr_inc(r_timer);
    // Release fires on the clock whose increment reaches HOLDOFF. The timeout
    // path preloads HOLDOFF, so it releases on the very next clock.
    assign w_rel_done = (w_tmr_inc >= TMR_W'(HOLDOFF));

    gc_rr_pick #(
        .N     (N_PORTS),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req    (w_fall),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        // Outside IDLE any fall on a non-granted port is a drop; falls on the
        // granted port are part of its own conversation.
        w_drop      = w_fall & ~r_grant;
        case (r_state)
            S_IDLE: begin
                w_drop = w_fall & ~w_onehot;
                if (w_any) begin
                    w_grant_nxt = w_onehot;
                    w_sel_nxt   = w_idx;
                    w_last_nxt  = w_idx;
                    w_timer_nxt = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (i_core_busy) begin
                    w_state_nxt = S_ACTIVE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_timer_nxt = TMR_W'(HOLDOFF);
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_timer_nxt = w_tmr_inc;
                end
            end
            S_ACTIVE: begin
                if (!i_core_busy) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A re-poll on the same port takes priority over release.
                if (i_core_busy) begin
                    w_state_nxt = S_ACTIVE;
                end else if (!w_sel_rx) begin
                    w_timer_nxt = '0;
                end else if (w_rel_done) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = w_tmr_inc;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_prev <= '1;
            r_grant   <= '0;
            r_sel     <= '0;
            r_last    <= SEL_W'(N_PORTS - 1);
            r_state   <= S_IDLE;
            r_timer   <= '0;
        end else begin
            r_rx_prev <= i_port_rx;
            r_grant   <= w_grant_nxt;
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    // Datapath is driven from the registered grant only, so a reset drops
    // every line back to released without waiting for a clock.
    assign o_core_rx  = (|r_grant) ? w_sel_rx : 1'b1;
    assign o_port_tx  = ~r_grant | {N_PORTS{i_core_tx}};
    assign o_core_sel = r_sel;
    assign o_grant    = r_grant;
    assign o_state    = r_state;

`ifdef GC_ARB_STATS_EN
    logic [7:0] r_drop [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_drop
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_drop[gi] <= 8'd0;
            end else if (w_drop[gi] && (r_drop[gi] != 8'hFF)) begin
                r_drop[gi] <= r_drop[gi] + 8'd1;
            end
        end
        assign o_drop_count[8*gi +: 8] = r_drop[gi];
    end
`else
    logic w_unused_drop;
    assign w_unused_drop = ^w_drop;
`endif

endmodule

// File: tb/tb_gc_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gc_port_arbiter
// Directed bench for gc_port_arbiter (N_PORTS=4, TIMEOUT=2000, HOLDOFF=64).
// Drop-counter checks are compiled in when GC_ARB_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_gc_port_arbiter;
    import gc_arb_pkg::*;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int TO = 2000;
    localparam int HO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  port_rx;
    logic [N-1:0]  port_tx;
    logic          core_rx;
    logic          core_tx;
    logic          core_busy;
    logic [SW-1:0] core_sel;
    logic [N-1:0]  grant;
    logic [1:0]    state;
`ifdef GC_ARB_STATS_EN
    logic [8*N-1:0] drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gc_port_arbiter #(
        .N_PORTS (N),
        .SEL_W   (SW),
        .TIMEOUT (TO),
        .HOLDOFF (HO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_port_rx    (port_rx),
        .o_port_tx    (port_tx),
        .o_core_rx    (core_rx),
        .i_core_tx    (core_tx),
        .i_core_busy  (core_busy),
        .o_core_sel   (core_sel),
        .o_grant      (grant),
`ifdef GC_ARB_STATS_EN
        .o_drop_count (drop_count),
`endif
        .o_state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        port_rx   = 4'hF;
        core_tx   = 1'b1;
        core_busy = 1'b0;
        step(2);
        chk("rst_grant",  grant, 4'h0);
        chk("rst_sel",    core_sel, 2'd0);
        chk("rst_tx",     port_tx, 4'hF);
        chk("rst_corerx", core_rx, 1'b1);
        chk("rst_state",  state, S_IDLE);
`ifdef GC_ARB_STATS_EN
        chk("rst_drop",   drop_count, 32'h0);
`endif
        reset = 1'b0;
        step(1);

        // 1: single poll on port 2
        port_rx = 4'b1011;
        step(1);
        chk("t1_grant",  grant, 4'b0100);
        chk("t1_sel",    core_sel, 2'd2);
        chk("t1_state",  state, S_GRANT);
        chk("t1_corerx", core_rx, 1'b0);
        chk("t1_tx_idle", port_tx, 4'hF);
        core_tx = 1'b0;
        #1;
        chk("t1_tx_drive", port_tx, 4'b1011);
        core_busy = 1'b1;
        port_rx   = 4'hF;
        step(1);
        chk("t1_active", state, S_ACTIVE);
        chk("t1_corerx_hi", core_rx, 1'b1);
        step(298);
        core_busy = 1'b0;
        core_tx   = 1'b1;
        step(1);
        chk("t1_release", state, S_RELEASE);
        step(HO - 1);
        chk("t1_hold_grant", grant, 4'b0100);
        step(1);
        chk("t1_free_grant", grant, 4'h0);
        chk("t1_free_state", state, S_IDLE);
        chk("t1_sel_kept",   core_sel, 2'd2);

        // 2: simultaneous falls on ports 0 and 1 after reset
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        port_rx = 4'b1100;
        step(1);
        chk("t2_grant0", grant, 4'b0001);
        chk("t2_sel0",   core_sel, 2'd0);
`ifdef GC_ARB_STATS_EN
        chk("t2_drop_a", drop_count, 32'h0000_0100);
`endif
        port_rx   = 4'hF;
        core_busy = 1'b1;
        step(1);
        core_busy = 1'b0;
        step(1);
        step(HO);
        chk("t2_free", grant, 4'h0);
        port_rx = 4'b1100;
        step(1);
        chk("t2_grant1", grant, 4'b0010);
        chk("t2_sel1",   core_sel, 2'd1);
`ifdef GC_ARB_STATS_EN
        chk("t2_drop_b", drop_count, 32'h0000_0101);
`endif

        // 4: contention on port 0 while port 1 is active
        port_rx   = 4'hF;
        core_busy = 1'b1;
        step(1);
        chk("t4_active", state, S_ACTIVE);
        for (int i = 0; i < 5; i++) begin
            port_rx = 4'b1110;
            step(1);
            port_rx = 4'hF;
            step(1);
        end
        chk("t4_grant5", grant, 4'b0010);
`ifdef GC_ARB_STATS_EN
        chk("t4_drop5", drop_count, 32'h0000_0106);
`endif
        for (int i = 0; i < 300; i++) begin
            port_rx = 4'b1110;
            step(1);
            port_rx = 4'hF;
            step(1);
        end
        chk("t4_grant_sat", grant, 4'b0010);
        chk("t4_sel_sat",   core_sel, 2'd1);
`ifdef GC_ARB_STATS_EN
        chk("t4_drop_sat", drop_count, 32'h0000_01FF);
`endif

        // 5: re-poll during release, then holdoff restart by granted port
        core_busy = 1'b0;
        step(1);
        chk("t5_release", state, S_RELEASE);
        step(10);
        port_rx   = 4'b1101;
        core_busy = 1'b1;
        step(1);
        chk("t5_repoll_state", state, S_ACTIVE);
        chk("t5_repoll_grant", grant, 4'b0010);
        port_rx   = 4'hF;
        core_busy = 1'b0;
        step(1);
        step(20);
        chk("t5_rel2", state, S_RELEASE);
        port_rx = 4'b1101;
        step(3);
        chk("t5_low_grant", grant, 4'b0010);
        port_rx = 4'hF;
        step(HO - 1);
        chk("t5_restart_hold", grant, 4'b0010);
        step(1);
        chk("t5_free_grant", grant, 4'h0);
        chk("t5_free_state", state, S_IDLE);
`ifdef GC_ARB_STATS_EN
        chk("t5_no_drop", drop_count, 32'h0000_01FF);
`endif

        // 3: timeout on port 3 (last=1, so search starts at 2)
        port_rx = 4'b0111;
        step(1);
        chk("t3_grant", grant, 4'b1000);
        chk("t3_sel",   core_sel, 2'd3);
        port_rx = 4'hF;
        step(TO - 1);
        chk("t3_pre_to_state", state, S_GRANT);
        step(1);
        chk("t3_to_state", state, S_RELEASE);
        chk("t3_to_grant", grant, 4'b1000);
        step(1);
        chk("t3_free_grant", grant, 4'h0);
        chk("t3_free_state", state, S_IDLE);

        // 6: asynchronous reset mid-response on port 1 (last=3, search from 0)
        port_rx = 4'b1101;
        step(1);
        chk("t6_grant", grant, 4'b0010);
        port_rx = 4'hF;
        core_tx = 1'b0;
        #1;
        chk("t6_tx_low", port_tx, 4'b1101);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_tx_rel",  port_tx, 4'hF);
        chk("t6_grant0",  grant, 4'h0);
        chk("t6_state",   state, S_IDLE);
        chk("t6_corerx",  core_rx, 1'b1);
`ifdef GC_ARB_STATS_EN
        chk("t6_drop0",   drop_count, 32'h0);
`endif
        step(1);
        reset   = 1'b0;
        core_tx = 1'b1;
        step(2);
        chk("t6_post_idle", grant, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
